// File: rtl/ubrcl_add_pipe.sv
// Two-stage ready/valid pipeline around the 31-bit ripple-block
// carry-look-ahead adder (UBRCL_30_0_30_0).
// Stage 1 holds the operands and feeds the adder, and stage 2 holds the sum.
// A saturating counter tracks how many delivered sums had carry-out set.
module ubrcl_add_pipe #(
  parameter int WIDTH = 31,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out_sum,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] carry_cnt,
  input  logic             cnt_clr
);

  // Look-ahead block size inside the adder. Carries ripple between blocks.
  localparam int BLK = 4;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_x;
  logic [WIDTH-1:0] s1_y;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_valid;
  logic [WIDTH:0]   s2_sum;
  logic [TAG_W-1:0] s2_tag;

  logic             s2_ld;
  logic             s1_free;
  logic             in_fire;
  logic             out_fire;

  logic [WIDTH-1:0] gen_b;
  logic [WIDTH-1:0] prop_b;
  logic [WIDTH:0]   carry;
  logic             grp_g;
  logic             grp_p;
  logic [WIDTH:0]   sum_c;

  // Handshake and advance decisions.
  // in_ready depends combinationally on out_ready through s2_ld.
  always_comb begin
    s2_ld    = s1_valid & (~s2_valid | out_ready);
    s1_free  = ~s1_valid | s2_ld;
    in_ready = s1_free & ~rst;
    in_fire  = in_valid & in_ready;
    out_fire = s2_valid & out_ready;
  end

  // UBRCL_30_0_30_0: inside each 4-bit block, every carry comes from the
  // group generate/propagate and the block carry-in. The block carry-out
  // then ripples into the next block. There is no carry-in.
  always_comb begin
    gen_b  = s1_x & s1_y;
    prop_b = s1_x ^ s1_y;
    carry  = '0;
    grp_g  = 1'b0;
    grp_p  = 1'b1;
    for (int b = 0; b < WIDTH; b += BLK) begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int i = b; (i < b + BLK) && (i < WIDTH); i++) begin
        grp_g        = gen_b[i] | (prop_b[i] & grp_g);
        grp_p        = prop_b[i] & grp_p;
        carry[i + 1] = grp_g | (grp_p & carry[b]);
      end
    end
    sum_c = {carry[WIDTH], prop_b ^ carry[WIDTH-1:0]};
  end

  // Stage 1: capture the operands whenever the slot is free or is being vacated.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_tag   <= '0;
    end else begin
      if (s1_free) s1_valid <= in_valid;
      if (in_fire) begin
        s1_x   <= in_x;
        s1_y   <= in_y;
        s1_tag <= in_tag;
      end
    end
  end

  // Stage 2: capture the sum. Hold it steady while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_tag   <= '0;
    end else if (s2_ld) begin
      s2_valid <= 1'b1;
      s2_sum   <= sum_c;
      s2_tag   <= s1_tag;
    end else if (out_fire) begin
      s2_valid <= 1'b0;
    end
  end

  // Carry-out statistics: clear wins over increment, and the count saturates at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      carry_cnt <= '0;
    end else if (cnt_clr) begin
      carry_cnt <= '0;
    end else if (out_fire && s2_sum[WIDTH] && !(&carry_cnt)) begin
      carry_cnt <= carry_cnt + CNT_W'(1);
    end
  end

  // Stage 2 drives the outputs directly.
  always_comb begin
    out_valid = s2_valid;
    out_sum   = s2_sum;
    out_tag   = s2_tag;
  end

endmodule

// File: tb/tb_ubrcl_add_pipe.sv
// Bench for ubrcl_add_pipe. It runs a 16-bit-counter instance and a
// 2-bit-counter instance from the same stimulus. A queue scoreboard holds
// the expected sums and tags in acceptance order.
module tb_ubrcl_add_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        cnt_clr;
  logic [30:0] in_x;
  logic [30:0] in_y;
  logic [3:0]  in_tag;

  logic        in_ready,  out_valid;
  logic [31:0] out_sum;
  logic [3:0]  out_tag;
  logic [15:0] carry_cnt;

  logic        in_ready_s, out_valid_s;
  logic [31:0] out_sum_s;
  logic [3:0]  out_tag_s;
  logic [1:0]  carry_cnt_s;

  always #5 clk = ~clk;

  ubrcl_add_pipe #(.WIDTH(31), .TAG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_tag(out_tag),
    .carry_cnt(carry_cnt), .cnt_clr(cnt_clr)
  );

  ubrcl_add_pipe #(.WIDTH(31), .TAG_W(4), .CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_x(in_x), .in_y(in_y), .in_tag(in_tag), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_sum(out_sum_s), .out_tag(out_tag_s),
    .carry_cnt(carry_cnt_s), .cnt_clr(cnt_clr)
  );

  typedef struct {
    logic [31:0] sum;
    logic [3:0]  tag;
  } exp_t;

  typedef struct {
    logic [30:0] x;
    logic [30:0] y;
    logic [3:0]  tag;
    logic [31:0] sum;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_err = 0;
  int   model_cnt = 0;
  int   model_cnt_s = 0;
  logic last_acc;
  logic stall_seen;

  function automatic logic [31:0] ref_sum(input logic [30:0] x, input logic [30:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives the inputs for one cycle after a falling edge and checks the outputs.
  // It updates the scoreboard and models from this cycle's handshakes,
  // then crosses the rising edge and checks the counters.
  task automatic step(input logic iv, input logic [30:0] x, input logic [30:0] y,
                      input logic [3:0] tag, input logic [31:0] esum,
                      input logic ordy, input logic clr);
    exp_t e;
    logic accept;
    logic deliver;
    logic in_rst;
    in_valid  = iv;
    in_x      = x;
    in_y      = y;
    in_tag    = tag;
    out_ready = ordy;
    cnt_clr   = clr;
    in_rst    = rst;
    #1;
    if (in_rst) begin
      check("in_ready_in_rst", 32'(in_ready), 32'd0);
      check("in_ready_s_in_rst", 32'(in_ready_s), 32'd0);
    end
    if (out_valid) begin
      if (sb.size() == 0) check("spurious_out", 32'(out_valid), 32'd0);
      else begin
        check("out_sum", out_sum, sb[0].sum);
        check("out_tag", 32'(out_tag), 32'(sb[0].tag));
      end
    end
    if (out_valid_s) begin
      if (sb.size() == 0) check("spurious_out_s", 32'(out_valid_s), 32'd0);
      else check("out_sum_s", out_sum_s, sb[0].sum);
    end
    if (!in_rst && !ordy && sb.size() >= 2) begin
      check("in_ready_full", 32'(in_ready), 32'd0);
      stall_seen = 1'b1;
    end
    accept   = iv & in_ready & ~in_rst;
    deliver  = out_valid & ordy & ~in_rst;
    last_acc = accept;
    e.sum = '0;
    e.tag = '0;
    if (deliver && sb.size() > 0) e = sb.pop_front();
    if (in_rst) begin
      sb.delete();
      model_cnt   = 0;
      model_cnt_s = 0;
    end else if (clr) begin
      model_cnt   = 0;
      model_cnt_s = 0;
    end else if (deliver && e.sum[31]) begin
      if (model_cnt < 65535) model_cnt++;
      if (model_cnt_s < 3) model_cnt_s++;
    end
    if (accept) begin
      e.sum = esum;
      e.tag = tag;
      sb.push_back(e);
    end
    @(negedge clk);
    check("carry_cnt", 32'(carry_cnt), 32'(model_cnt));
    check("carry_cnt_s", 32'(carry_cnt_s), 32'(model_cnt_s));
    if (in_rst) begin
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_sum", out_sum, 32'd0);
      check("rst_out_tag", 32'(out_tag), 32'd0);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() > 0; i++) step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [30:0] rx, ry;
    int          idx;
    logic        ordy;

    vecs[0] = '{31'h7FFF_FFFF, 31'h0000_0001, 4'h3, 32'h8000_0000};
    vecs[1] = '{31'h7FFF_FFFF, 31'h7FFF_FFFF, 4'h1, 32'hFFFF_FFFE};
    vecs[2] = '{31'h0000_0000, 31'h0000_0000, 4'h0, 32'h0000_0000};
    vecs[3] = '{31'h0000_0005, 31'h0000_0009, 4'h5, 32'h0000_000E};
    vecs[4] = '{31'h5555_5555, 31'h2AAA_AAAA, 4'h7, 32'h7FFF_FFFF};
    vecs[5] = '{31'h4000_0000, 31'h4000_0000, 4'h8, 32'h8000_0000};
    vecs[6] = '{31'h1234_5678, 31'h0FED_CBA9, 4'hA, 32'h2222_2221};
    vecs[7] = '{31'h7FFF_FFFF, 31'h0000_0000, 4'hF, 32'h7FFF_FFFF};

    stall_seen = 1'b0;
    last_acc   = 1'b0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
    in_x = '0; in_y = '0; in_tag = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step(1'b1, 31'h1, 31'h2, 4'h9, 32'h3, 1'b1, 1'b0);
    rst = 1'b0;

    // Single transaction: accepted at edge k, with out_valid set after edge k+1.
    step(1'b1, 31'h7FFF_FFFF, 31'h1, 4'h3, 32'h8000_0000, 1'b1, 1'b0);
    check("first_accept", 32'(last_acc), 32'd1);
    check("lat_after_k", 32'(out_valid), 32'd0);
    step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    check("lat_after_k1", 32'(out_valid), 32'd1);
    check("single_sum", out_sum, 32'h8000_0000);
    check("single_tag", 32'(out_tag), 32'd3);
    step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    check("single_cnt", 32'(carry_cnt), 32'd1);
    check("single_done", 32'(out_valid), 32'd0);

    // Directed table, streamed back to back.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, vecs[i].x, vecs[i].y, vecs[i].tag, vecs[i].sum, 1'b1, 1'b0);
      check("table_accept", 32'(last_acc), 32'd1);
    end
    drain();
    check("table_cnt", 32'(carry_cnt), 32'd4);

    // 100 random pairs, with tags cycling 0..15.
    for (int i = 0; i < 100; i++) begin
      rx = 31'($urandom);
      ry = 31'($urandom);
      step(1'b1, rx, ry, 4'(i), ref_sum(rx, ry), 1'b1, 1'b0);
      check("stream_accept", 32'(last_acc), 32'd1);
    end
    drain();

    // Backpressure: out_ready is low during cycles 3..8.
    idx = 0;
    rx  = 31'($urandom);
    ry  = 31'($urandom);
    for (int c = 0; c < 60 && idx < 10; c++) begin
      ordy = !(c >= 3 && c <= 8);
      step(1'b1, rx, ry, 4'(idx), ref_sum(rx, ry), ordy, 1'b0);
      if (last_acc) begin
        idx++;
        rx = 31'($urandom);
        ry = 31'($urandom);
      end
    end
    check("bp_all_accepted", 32'(idx), 32'd10);
    check("bp_stall_seen", 32'(stall_seen), 32'd1);
    drain();

    // Random valid/ready traffic with occasional counter clears.
    for (int c = 0; c < 2000; c++) begin
      rx = 31'($urandom);
      ry = 31'($urandom);
      step(1'($urandom_range(0, 1)), rx, ry, 4'($urandom_range(0, 15)), ref_sum(rx, ry),
           1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 99) == 0));
    end
    drain();

    // Saturation of the 2-bit counter, then a clear on the same cycle as a carry handshake.
    step(1'b0, '0, '0, '0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++)
      step(1'b1, 31'h7FFF_FFFF, 31'h7FFF_FFFF, 4'(i), 32'hFFFF_FFFE, 1'b1, 1'b0);
    drain();
    check("sat_cnt_s", 32'(carry_cnt_s), 32'd3);
    check("sat_cnt", 32'(carry_cnt), 32'd5);
    step(1'b1, 31'h7FFF_FFFF, 31'h7FFF_FFFF, 4'hC, 32'hFFFF_FFFE, 1'b0, 1'b0);
    for (int i = 0; i < 5 && !out_valid; i++) step(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    check("clr_pending_valid", 32'(out_valid), 32'd1);
    step(1'b0, '0, '0, '0, '0, 1'b1, 1'b1);
    check("clr_cnt", 32'(carry_cnt), 32'd0);
    check("clr_cnt_s", 32'(carry_cnt_s), 32'd0);

    // Reset with both stages full and downstream stalled.
    for (int i = 0; i < 4; i++) begin
      rx = 31'($urandom) | 31'h4000_0000;
      step(1'b1, rx, rx, 4'(i), ref_sum(rx, rx), 1'b0, 1'b0);
    end
    check("pre_rst_full", 32'(sb.size()), 32'd2);
    rst = 1'b1;
    step(1'b1, 31'h3, 31'h4, 4'h2, 32'h7, 1'b0, 1'b0);
    rst = 1'b0;
    step(1'b1, 31'd5, 31'd9, 4'h6, 32'd14, 1'b1, 1'b0);
    check("post_rst_accept", 32'(last_acc), 32'd1);
    step(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
    check("post_rst_sum", out_sum, 32'd14);
    check("post_rst_tag", 32'(out_tag), 32'd6);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
